// File: rtl/ifetch_if.sv
// Byte-wide instruction memory port shared between the fetch stage (master)
// and the memory/arbiter side (slave).
// Handshake: mem_re is high only in a cycle where mem_gnt is high. In that
// cycle mem_a is the byte address being read. The addressed byte appears on
// mem_din in the following cycle. There is no back-pressure beyond mem_gnt.
interface ifetch_if;
   logic [31:0] mem_a;
   logic        mem_re;
   logic        mem_gnt;
   logic [7:0]  mem_din;

   modport master (output mem_a, output mem_re, input mem_gnt, input mem_din);
   modport slave  (input mem_a, input mem_re, output mem_gnt, output mem_din);
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage.
// - Reads each 32-bit instruction one byte at a time, little-endian, over the
//   shared byte-wide memory port.
// - Hands {pc+4, instruction} to decode for one cycle; is = 0 is a bubble.
// - A redirect (br_e/br_pc) flushes the stream and restarts fetching at br_pc.
// Optional macro ICACHE_EN adds a direct-mapped word cache of ICACHE_LINES
// lines. A hit in S0 serves the instruction with no memory traffic.
module ifetch #(
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          ICACHE_LINES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_e,
   input  logic [31:0] br_pc,
   ifetch_if.master    bus,
   output logic [31:0] pc,
   output logic [31:0] is,
   output logic [2:0]  dbg_state
);

   // Sk = k bytes of the current instruction requested so far.
   typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] is_q, is_d;
   logic [31:0] buf_q, buf_d;
   logic [2:0]  rc_q, rc_d;
   logic        pend_q, pend_d;
   logic        req;
   logic [31:0] req_a;
   logic        hit;
   logic [31:0] hit_word;
   logic        fill;

`ifdef ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [31:0]             line_data [ICACHE_LINES];
   logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] line_vld_q;
   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;

   assign idx      = fpc_q[IDX_W+1:2];
   assign tag      = fpc_q[31:IDX_W+2];
   assign hit      = (state_q == S0) && !stall && line_vld_q[idx] && (line_tag[idx] == tag);
   assign hit_word = line_data[idx];

   // Line fill at completion of a byte-assembled fetch; storage needs no reset.
   always_ff @(posedge clk) begin
      if (fill) begin
         line_data[idx] <= buf_d;
         line_tag[idx]  <= tag;
      end
   end

   // Valid bits are only ever cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_vld_q <= '0;
      end else if (fill) begin
         line_vld_q[idx] <= 1'b1;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = 32'h0;
`endif

   // Next state: byte capture, request issue, completion or cache hit, then
   // the redirect override, which wins over everything else.
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      pc_d    = pc_q;
      is_d    = 32'h0;
      buf_d   = buf_q;
      rc_d    = rc_q;
      req     = 1'b0;
      req_a   = 32'h0;
      fill    = 1'b0;

      // A byte in flight is captured regardless of grant or stall.
      if (pend_q) begin
         buf_d[{rc_q[1:0], 3'b000} +: 8] = bus.mem_din;
         rc_d = rc_q + 3'd1;
      end

      if (!rst && !stall && !hit && bus.mem_gnt && (state_q != S4)) begin
         req     = 1'b1;
         req_a   = fpc_q + {29'h0, state_q};
         state_d = state_t'(state_q + 3'd1);
      end
      pend_d = req;

      // Completion merges with the capture of the fourth byte, giving one
      // instruction every 5 cycles with continuous grant.
      if (stall) begin
         is_d = is_q;
      end else if (rc_d == 3'd4) begin
         is_d    = buf_d;
         pc_d    = fpc_q + 32'd4;
         fpc_d   = fpc_q + 32'd4;
         state_d = S0;
         rc_d    = 3'd0;
         fill    = 1'b1;
      end else if (hit) begin
         is_d  = hit_word;
         pc_d  = fpc_q + 32'd4;
         fpc_d = fpc_q + 32'd4;
      end

      // A byte still in flight belongs to the old stream and is dropped.
      if (br_e) begin
         fpc_d   = br_pc;
         state_d = S0;
         rc_d    = 3'd0;
         pend_d  = 1'b0;
         is_d    = 32'h0;
         pc_d    = 32'h0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S0;
         fpc_q   <= RESET_PC;
         pc_q    <= 32'h0;
         is_q    <= 32'h0;
         buf_q   <= 32'h0;
         rc_q    <= 3'd0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         pc_q    <= pc_d;
         is_q    <= is_d;
         buf_q   <= buf_d;
         rc_q    <= rc_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.mem_re = req;
   assign bus.mem_a  = req_a;
   assign pc         = pc_q;
   assign is         = is_q;
   assign dbg_state  = state_q;

endmodule
